// File: rtl/shad_reg_ctrl_pkg.sv
// Shared types and sizing helpers for the shadow register sequencer.
//  state_e    : sequencer states
//  SettleCntW : width of the settle-delay counter (SETTLE_CYC limited to 0..15)
//  cnt_w()    : bit-counter width able to hold 0..total
package shad_reg_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCapture,
      StSettle,
      StShift,
      StDone
   } state_e;

   localparam int unsigned SettleCntW = 4;

   function automatic int unsigned cnt_w(input int unsigned total);
      return $clog2(total + 1);
   endfunction

endpackage

// File: rtl/shad_reg_deser.sv
// Bit counter plus indexed-write deserializer for the shadow chain readout.
//  clk, rst_n : clock, asynchronous active-low reset
//  clear      : return the bit counter to 0 (wins over shift_en, no data write)
//  shift_en   : current cycle is a shift cycle; so_in lands in rd_data[count]
//  so_in      : serial data from the chain tail
//  rd_data    : deserialized word, bit 0 is the first bit shifted out
//  last       : count == TOTAL-1, i.e. this is the final shift cycle
module shad_reg_deser
   import shad_reg_ctrl_pkg::*;
#(
   parameter int unsigned TOTAL = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             so_in,
   output logic [TOTAL-1:0] rd_data,
   output logic             last
);

   localparam int unsigned     CntW    = cnt_w(TOTAL);
   localparam logic [CntW-1:0] CntLast = CntW'(TOTAL - 1);

   logic [CntW-1:0]  cnt_d, cnt_q;
   logic [TOTAL-1:0] data_d, data_q;

   always_comb begin
      cnt_d  = cnt_q;
      data_d = data_q;
      if (clear) begin
         cnt_d = '0;
      end else if (shift_en) begin
         cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
         // Decoded write keeps the index compare at the counter's own width.
         for (int unsigned i = 0; i < TOTAL; i++) begin
            if (cnt_q == CntW'(i)) data_d[i] = so_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         data_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         data_q <= data_d;
      end
   end

   assign rd_data = data_q;
   assign last    = (cnt_q == CntLast);

endmodule

// File: rtl/shad_reg_ctrl.sv
// Sequencer for a chain of NUM_REGS shadow registers of WIDTH bits each: captures the system
// registers into the shadows, shifts the chain out and returns the deserialized word over a
// valid/ready port.
//  snap_req / snap_ack : level request, one-cycle acceptance pulse
//  abort               : synchronous abort of an in-flight sequence
//  shad_clk_en, se, si : shadow bank clock enable, scan enable, chain head data
//  so_in               : chain tail data
//  busy                : sequencer not idle
//  rd_valid/rd_ready/rd_data : snapshot result handshake
// Build option: define SHAD_REG_CTRL_RECIRC_EN to feed so_in back into si while shifting so the
// chain is restored after readout; otherwise FILL_VAL is shifted in.
module shad_reg_ctrl
   import shad_reg_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned NUM_REGS   = 1,
   parameter int unsigned SETTLE_CYC = 1,
   parameter logic        FILL_VAL   = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      snap_req,
   output logic                      snap_ack,
   input  logic                      abort,
   output logic                      shad_clk_en,
   output logic                      se,
   output logic                      si,
   input  logic                      so_in,
   output logic                      busy,
   output logic                      rd_valid,
   input  logic                      rd_ready,
   output logic [WIDTH*NUM_REGS-1:0] rd_data
);

   localparam int unsigned TOTAL = WIDTH * NUM_REGS;
   localparam logic [SettleCntW-1:0] SettleLast =
      (SETTLE_CYC > 0) ? SettleCntW'(SETTLE_CYC - 1) : '0;

   state_e                state_d, state_q;
   logic [SettleCntW-1:0] settle_cnt_d, settle_cnt_q;
   logic                  snap_ack_d, snap_ack_q;
   logic                  clk_en_d, clk_en_q;
   logic                  se_d, se_q;
   logic                  busy_d, busy_q;
   logic                  rd_valid_d, rd_valid_q;
   logic                  deser_clear;
   logic                  deser_last;

   always_comb begin
      state_d      = state_q;
      settle_cnt_d = '0;
      snap_ack_d   = 1'b0;
      deser_clear  = 1'b0;
      if (abort && (state_q != StIdle)) begin
         // Abort beats rd_ready and the counter wrap.
         state_d     = StIdle;
         deser_clear = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (snap_req && !abort) begin
                  state_d    = StCapture;
                  snap_ack_d = 1'b1;
               end
            end
            StCapture: state_d = (SETTLE_CYC > 0) ? StSettle : StShift;
            StSettle: begin
               if (settle_cnt_q == SettleLast) state_d = StShift;
               else settle_cnt_d = settle_cnt_q + SettleCntW'(1);
            end
            StShift: if (deser_last) state_d = StDone;
            StDone:  if (rd_ready) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
      // Outputs are decoded from the next state and registered, so the ICG enable is glitch-free.
      clk_en_d   = (state_d == StCapture) || (state_d == StShift);
      se_d       = (state_d == StShift);
      busy_d     = (state_d != StIdle);
      rd_valid_d = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         settle_cnt_q <= '0;
         snap_ack_q   <= 1'b0;
         clk_en_q     <= 1'b0;
         se_q         <= 1'b0;
         busy_q       <= 1'b0;
         rd_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         snap_ack_q   <= snap_ack_d;
         clk_en_q     <= clk_en_d;
         se_q         <= se_d;
         busy_q       <= busy_d;
         rd_valid_q   <= rd_valid_d;
      end
   end

   shad_reg_deser #(
      .TOTAL(TOTAL)
   ) u_deser (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (deser_clear),
      .shift_en(state_q == StShift),
      .so_in   (so_in),
      .rd_data (rd_data),
      .last    (deser_last)
   );

`ifdef SHAD_REG_CTRL_RECIRC_EN
   assign si = se_q ? so_in : 1'b0;
`else
   assign si = se_q ? FILL_VAL : 1'b0;
`endif

   assign snap_ack    = snap_ack_q;
   assign shad_clk_en = clk_en_q;
   assign se          = se_q;
   assign busy        = busy_q;
   assign rd_valid    = rd_valid_q;

endmodule
